// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store data memory: funct3 codes, FSM states
// and the size/legality helpers used by both the top level and the lane aligner.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Access size in bytes; the low two funct3 bits encode log2(size).
  function automatic int size_bytes(input logic [2:0] funct3);
    return 1 << funct3[1:0];
  endfunction

  // Whether a funct3 code names a real load/store at the given data width.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3, input int xlen);
    logic wide;
    wide = (xlen == 64);
    if (we)
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
             (wide && (funct3 == F3_D));
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU) ||
           (wide && ((funct3 == F3_D) || (funct3 == F3_WU)));
  endfunction

endpackage

// File: rtl/lsu_mem_lane_align.sv
// Byte-lane steering for one memory word: merges store data into the selected
// lanes and extracts/extends the selected lanes for loads.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] offset_i,
  input  logic [2:0]                funct3_i,
  input  logic [XLEN-1:0]           word_i,
  input  logic [XLEN-1:0]           wdata_i,
  output logic [XLEN-1:0]           st_word_o,
  output logic [XLEN-1:0]           ld_val_o
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] shifted;
  int              sz;

  assign shifted = word_i >> {offset_i, 3'b000};

  // Replace only the lanes covered by [offset, offset+size) with the low store bytes.
  always_comb begin
    sz        = size_bytes(funct3_i);
    st_word_o = word_i;
    for (int i = 0; i < NB; i++) begin
      if ((i >= int'(offset_i)) && (i < int'(offset_i) + sz))
        st_word_o[i*8 +: 8] = wdata_i[(i - int'(offset_i))*8 +: 8];
    end
  end

  // Right-aligned load lane, sign- or zero-extended to the full width.
  always_comb begin
    case (funct3_i)
      F3_B:    ld_val_o = XLEN'($signed(shifted[7:0]));
      F3_H:    ld_val_o = XLEN'($signed(shifted[15:0]));
      F3_W:    ld_val_o = XLEN'($signed(shifted[31:0]));
      F3_BU:   ld_val_o = XLEN'(shifted[7:0]);
      F3_HU:   ld_val_o = XLEN'(shifted[15:0]);
      F3_WU:   ld_val_o = XLEN'(shifted[31:0]);
      default: ld_val_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Data memory with an integrated load/store unit. One request in flight;
// legal accesses complete after LATENCY cycles, faulting ones after one cycle
// without touching the array.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int    XLEN        = 32,
  parameter int    DEPTH_WORDS = 256,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  lsu_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            we_q;
  logic [2:0]      funct3_q;
  logic [IDX_W-1:0] idx_q;
  logic [OFF_W-1:0] off_q;
  logic [XLEN-1:0] wdata_q;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic [XLEN-1:0] word, st_word, ld_val;
  logic            accept, aligned, in_range, legal, write_now;

  assign accept    = (state_q == IDLE) && req_valid;
  assign aligned   = ((req_addr & (XLEN'(size_bytes(req_funct3)) - XLEN'(1))) == '0);
  assign in_range  = (req_addr >> OFF_W) < XLEN'(DEPTH_WORDS);
  assign legal     = is_legal(req_we, req_funct3, XLEN) && aligned && in_range;
  assign word      = mem_q[idx_q];
  assign write_now = (state_q == WAIT) && (cnt_q == '0) && we_q;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .offset_i  (off_q),
    .funct3_i  (funct3_q),
    .word_i    (word),
    .wdata_i   (wdata_q),
    .st_word_o (st_word),
    .ld_val_o  (ld_val)
  );

  // State, wait counter and response registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request latches capture the accepted access; they carry no reset.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      idx_q    <= req_addr[OFF_W +: IDX_W];
      off_q    <= req_addr[OFF_W-1:0];
      wdata_q  <= req_wdata;
    end
  end

  // Store commit on the WAIT->RESP edge; a coincident rst suppresses it.
  always_ff @(posedge clk) begin
    if (write_now && !rst) begin
      mem_q[idx_q] <= st_word;
`ifndef SYNTHESIS
      $display("lsu_mem: write addr=0x%0h data=0x%0h", {idx_q, {OFF_W{1'b0}}}, st_word);
`endif
    end
  end

  // Next-state, counter and response data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = ERR;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          rdata_d = we_q ? '0 : ld_val;
          err_d   = 1'b0;
        end
      end
      ERR: begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: directed scenarios plus random traffic, checked against
// a byte-array memory model.
module tb_lsu_mem;

  localparam int XLEN  = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  byte unsigned ref_mem [DEPTH*4];

  always #5 clk = ~clk;

  lsu_mem #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Byte-level reference: legality, store merge, load extension by arithmetic.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int     sz;
    longint v;
    bit     ok;
    ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 1 << f3[1:0];
    if (ok && (addr % sz) != 0) ok = 0;
    if (ok && (addr / 4) >= DEPTH) ok = 0;
    rd = '0;
    er = !ok;
    if (ok && we) begin
      for (int i = 0; i < sz; i++) ref_mem[addr + i] = wd[8*i +: 8];
    end else if (ok) begin
      v = 0;
      for (int i = 0; i < sz; i++) v += longint'(ref_mem[addr + i]) * (longint'(1) << (8*i));
      if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1))) v -= longint'(1) << (8*sz);
      rd = v[31:0];
    end
  endfunction

  // One complete transaction: accept, bounded wait, response check, handshake.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input bit early_rdy,
                      output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          cyc;
    model(we, f3, addr, wd, exp_rd, exp_er);
    check_eq({tag, ".req_ready"}, req_ready, 1);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (early_rdy) rsp_ready = 1;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, ".latency"}, cyc, exp_er ? 1 : LAT);
    rd = rsp_rdata;
    er = rsp_err;
    check_eq({tag, ".rdata"}, rsp_rdata, exp_rd);
    check_eq({tag, ".err"}, rsp_err, exp_er);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check_eq({tag, ".idle"}, {busy, rsp_valid, req_ready}, 3'b001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] rd, prior, exp_rd;
    logic        er, exp_er;
    int          cyc;

    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 0;

    // Reset with a request pending: it must be ignored.
    rst = 1; req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h10;
    req_wdata = 32'hBAD0BAD0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", {req_ready, rsp_valid, rsp_err, busy}, 4'b1000);
    check_eq("rst_rdata", rsp_rdata, 0);
    rst = 0; req_valid = 0;
    @(posedge clk); #1;
    check_eq("rst_req_ignored", busy, 0);

    // Word store/load.
    xact("sw10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check_eq("sw10_err", er, 0);
    xact("lw10", 0, 3'd2, 32'h10, 0, 0, rd, er);
    check_eq("lw10_val", rd, 32'hDEADBEEF);

    // Byte merge and extension.
    xact("sb11", 1, 3'd0, 32'h11, 32'h80, 0, rd, er);
    xact("lb11", 0, 3'd0, 32'h11, 0, 0, rd, er);
    check_eq("lb11_val", rd, 32'hFFFFFF80);
    xact("lbu11", 0, 3'd4, 32'h11, 0, 0, rd, er);
    check_eq("lbu11_val", rd, 32'h00000080);
    xact("lh10", 0, 3'd1, 32'h10, 0, 0, rd, er);
    check_eq("lh10_val", rd, 32'hFFFF80EF);
    xact("lw10b", 0, 3'd2, 32'h10, 0, 0, rd, er);
    check_eq("lw10b_val", rd, 32'hDEAD80EF);

    // Misaligned, out-of-range, illegal code; memory must be untouched.
    xact("lw12_mis", 0, 3'd2, 32'h12, 0, 0, rd, er);
    check_eq("lw12_mis_err", {er, rd}, {1'b1, 32'h0});
    xact("sh13_mis", 1, 3'd1, 32'h13, 32'hFFFF, 0, rd, er);
    check_eq("sh13_mis_err", {er, rd}, {1'b1, 32'h0});
    xact("lw_oor", 0, 3'd2, DEPTH*4, 0, 0, rd, er);
    check_eq("lw_oor_err", er, 1);
    xact("ld_f3_7", 0, 3'd7, 32'h10, 0, 0, rd, er);
    check_eq("ld_f3_7_err", er, 1);
    xact("sw_oor", 1, 3'd2, DEPTH*4 + 32'h10, 32'h55555555, 0, rd, er);
    check_eq("sw_oor_err", er, 1);
    xact("st_f3_7", 1, 3'd7, 32'h10, 32'h66666666, 0, rd, er);
    check_eq("st_f3_7_err", er, 1);
    xact("lw10c", 0, 3'd2, 32'h10, 0, 0, rd, er);
    check_eq("lw10c_unchanged", rd, 32'hDEAD80EF);

    // Fill the random region so every load has a defined expectation.
    for (int w = 0; w < 16; w++) xact("init", 1, 3'd2, 32'(w*4), $urandom, 0, rd, er);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = DEPTH*4 + $urandom_range(0, 255);
      else a = $urandom_range(0, 63);
      xact($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
           $urandom, 1'($urandom_range(0, 1)), rd, er);
    end

    // Backpressure: response held while rsp_ready is low; new request refused.
    model(0, 3'd2, 32'h10, 0, exp_rd, exp_er);
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 0;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("bp.latency", cyc, LAT);
    req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp.hold%0d", i), {rsp_valid, req_ready, busy, rsp_err, rsp_rdata},
               {1'b1, 1'b0, 1'b1, 1'b0, exp_rd});
      @(posedge clk); #1;
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check_eq("bp.idle", {busy, rsp_valid, req_ready}, 3'b001);
    xact("bp.after", 0, 3'd2, 32'h10, 0, 0, rd, er);

    // Reset on the store's write edge: no response, no write.
    model(0, 3'd2, 32'h20, 0, prior, exp_er);
    req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check_eq("rstw.wait", {busy, rsp_valid}, 2'b10);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check_eq("rstw.idle", {busy, rsp_valid, req_ready}, 3'b001);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstw.no_rsp", rsp_valid, 0);
    xact("rstw.lw20", 0, 3'd2, 32'h20, 0, 0, rd, er);
    check_eq("rstw.prior", rd, prior);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
